// File: rtl/sdram_port_pkg.sv
// sdram_port_pkg
//   Shared definitions for the SDRAM client-port responder: default widths
//   and timing constants, the responder state enum, and the burst descriptor
//   latched at grant time.
package sdram_port_pkg;

  localparam int DEF_ADDR_WIDTH     = 24;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_LEN_WIDTH      = 10;
  localparam int DEF_MEM_AW         = 12;
  localparam int DEF_REFRESH_PERIOD = 780;
  localparam int DEF_REFRESH_CYCLES = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REF,
    ST_WR,
    ST_RD_PRE,
    ST_RD,
    ST_DONE
  } state_e;

  // Burst captured in IDLE and held until DONE. Fields use the default
  // widths; the top casts into and out of them.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_LEN_WIDTH-1:0]  len;
    logic                      is_read;
  } burst_t;

endpackage

// File: rtl/simple_dp_ram.sv
// simple_dp_ram
//   Word memory with one write port and one synchronous read port
//   (1-cycle read latency). Contents are not initialised.
// Ports:
//   sys_clk_i            clock
//   wr_en/wr_addr/wr_data write port
//   rd_en/rd_addr         read request; rd_data updates on the next edge
//   rd_data               registered read data, holds when rd_en is low
module simple_dp_ram #(
  parameter int MEM_AW     = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  sys_clk_i,
  input  logic                  wr_en,
  input  logic [MEM_AW-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [MEM_AW-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

  // NOTE: the array and its read register have no reset, so the tool can map
  // them onto block RAM; a reset would force the array into flip-flops.
  always_ff @(posedge sys_clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sdram_port_responder.sv
// sdram_port_responder
//   Stand-in for the SDRAM controller on the client port. Arbitrates write
//   and read burst requests round-robin, stores words in on-chip RAM, paces
//   each burst with per-word acks and inserts periodic refresh blackouts.
// Ports:
//   sys_clk_i, rst_i            clock, async active-high reset
//   sdram_wr_*                  write channel (req/addr/data/length in, ack out)
//   sdram_rd_*                  read channel (req/addr/length in, data/ack out)
//   refresh_o                   high during a refresh blackout
//   busy_o                      high whenever the responder is not idle
module sdram_port_responder
  import sdram_port_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH      = DEF_LEN_WIDTH,
  parameter int MEM_AW         = DEF_MEM_AW,
  parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
  input  logic                  sys_clk_i,
  input  logic                  rst_i,
  input  logic                  sdram_wr_req_i,
  input  logic [ADDR_WIDTH-1:0] sdram_wr_addr_i,
  input  logic [DATA_WIDTH-1:0] sdram_wr_data_i,
  input  logic [LEN_WIDTH-1:0]  sdram_wr_length_i,
  output logic                  sdram_wr_ack_o,
  input  logic                  sdram_rd_req_i,
  input  logic [ADDR_WIDTH-1:0] sdram_rd_addr_i,
  input  logic [LEN_WIDTH-1:0]  sdram_rd_length_i,
  output logic [DATA_WIDTH-1:0] sdram_rd_data_o,
  output logic                  sdram_rd_ack_o,
  output logic                  refresh_o,
  output logic                  busy_o
);

  localparam int RFC_W = $clog2(REFRESH_PERIOD);

  state_e                state_q, state_d;
  burst_t                burst_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [RFC_W-1:0]      rfc_q;
  logic                  rfc_wrap;
  logic                  ref_pending_q;
  logic                  prefer_rd_q;
  logic                  grant_wr, grant_rd, last_word, take_grant;
  logic                  wr_ack_q, rd_ack_q;
  logic [DATA_WIDTH-1:0] ram_rdata, rd_hold_q;

  // Round-robin: on a tie the channel not served last wins.
  assign grant_wr   = sdram_wr_req_i && (!sdram_rd_req_i || !prefer_rd_q);
  assign grant_rd   = sdram_rd_req_i && (!sdram_wr_req_i ||  prefer_rd_q);
  assign take_grant = (state_q == ST_IDLE) && !ref_pending_q;

  assign len_q     = LEN_WIDTH'(burst_q.len);
  assign last_word = (cnt_q == len_q - LEN_WIDTH'(1));
  assign rfc_wrap  = (rfc_q == RFC_W'(REFRESH_PERIOD - 1));

  // In RD the RAM is already one word ahead of the ack (prefetch from RD_PRE).
  assign word_addr = ADDR_WIDTH'(burst_q.addr) + ADDR_WIDTH'(cnt_q)
                   + ADDR_WIDTH'(state_q == ST_RD);

  // NOTE: next state is assigned a default first so every path through the
  // case assigns it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ref_pending_q)
          state_d = ST_REF;
        else if (grant_wr)
          state_d = (sdram_wr_length_i == '0) ? ST_DONE : ST_WR;
        else if (grant_rd)
          state_d = (sdram_rd_length_i == '0) ? ST_DONE : ST_RD_PRE;
      end
      ST_REF:    if (cnt_q == LEN_WIDTH'(REFRESH_CYCLES - 1)) state_d = ST_IDLE;
      ST_WR:     if (last_word) state_d = ST_DONE;
      ST_RD_PRE: state_d = ST_RD;
      ST_RD:     if (last_word) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      prefer_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ack_q <= (state_d == ST_WR);
      rd_ack_q <= (state_d == ST_RD);
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q inside {ST_REF, ST_WR, ST_RD})
        cnt_q <= cnt_q + LEN_WIDTH'(1);
      // Every grant, including length 0, passes through DONE exactly once.
      if (state_q == ST_DONE)
        prefer_rd_q <= !burst_q.is_read;
    end
  end

  // Request fields are captured only at grant and held through the burst.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      burst_q <= '0;
    end else if (take_grant && grant_wr) begin
      burst_q <= '{addr:    DEF_ADDR_WIDTH'(sdram_wr_addr_i),
                   len:     DEF_LEN_WIDTH'(sdram_wr_length_i),
                   is_read: 1'b0};
    end else if (take_grant && grant_rd) begin
      burst_q <= '{addr:    DEF_ADDR_WIDTH'(sdram_rd_addr_i),
                   len:     DEF_LEN_WIDTH'(sdram_rd_length_i),
                   is_read: 1'b1};
    end
  end

  // Free-running refresh timer; a wrap while already pending is absorbed.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      rfc_q         <= '0;
      ref_pending_q <= 1'b0;
    end else begin
      rfc_q <= rfc_wrap ? '0 : rfc_q + RFC_W'(1);
      if (state_q == ST_IDLE && ref_pending_q)
        ref_pending_q <= 1'b0;
      else if (rfc_wrap)
        ref_pending_q <= 1'b1;
    end
  end

  // Read data holds the last delivered word between acks.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i)         rd_hold_q <= '0;
    else if (rd_ack_q) rd_hold_q <= ram_rdata;
  end

  simple_dp_ram #(
    .MEM_AW     (MEM_AW),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .sys_clk_i (sys_clk_i),
    .wr_en     (state_q == ST_WR),
    .wr_addr   (word_addr[MEM_AW-1:0]),
    .wr_data   (sdram_wr_data_i),
    .rd_en     (state_q == ST_RD_PRE || state_q == ST_RD),
    .rd_addr   (word_addr[MEM_AW-1:0]),
    .rd_data   (ram_rdata)
  );

  assign sdram_wr_ack_o  = wr_ack_q;
  assign sdram_rd_ack_o  = rd_ack_q;
  assign sdram_rd_data_o = rd_ack_q ? ram_rdata : rd_hold_q;
  assign refresh_o       = (state_q == ST_REF);
  assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_port_responder.sv
// tb_sdram_port_responder
//   Self-checking bench: reset values, a table of bursts with latency and
//   data checks, round-robin, length 0, refresh blackout, reset mid-burst and
//   randomized bursts checked against a word-array model of the memory.
module tb_sdram_port_responder;

  logic        sys_clk_i = 1'b0;
  logic        rst_i     = 1'b1;
  logic        sdram_wr_req_i = 1'b0;
  logic [23:0] sdram_wr_addr_i = '0;
  logic [15:0] sdram_wr_data_i = '0;
  logic [9:0]  sdram_wr_length_i = '0;
  logic        sdram_wr_ack_o;
  logic        sdram_rd_req_i = 1'b0;
  logic [23:0] sdram_rd_addr_i = '0;
  logic [9:0]  sdram_rd_length_i = '0;
  logic [15:0] sdram_rd_data_o;
  logic        sdram_rd_ack_o;
  logic        refresh_o;
  logic        busy_o;

  sdram_port_responder dut (
    .sys_clk_i         (sys_clk_i),
    .rst_i             (rst_i),
    .sdram_wr_req_i    (sdram_wr_req_i),
    .sdram_wr_addr_i   (sdram_wr_addr_i),
    .sdram_wr_data_i   (sdram_wr_data_i),
    .sdram_wr_length_i (sdram_wr_length_i),
    .sdram_wr_ack_o    (sdram_wr_ack_o),
    .sdram_rd_req_i    (sdram_rd_req_i),
    .sdram_rd_addr_i   (sdram_rd_addr_i),
    .sdram_rd_length_i (sdram_rd_length_i),
    .sdram_rd_data_o   (sdram_rd_data_o),
    .sdram_rd_ack_o    (sdram_rd_ack_o),
    .refresh_o         (refresh_o),
    .busy_o            (busy_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int cyc = 0;
  always @(posedge sys_clk_i) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int n0;                       // cycle in which reset was last released

  logic [15:0] shadow [4096];
  bit          valid  [4096];

  typedef struct {
    bit          is_rd;
    logic [23:0] addr;
    logic [9:0]  len;
    logic [15:0] base;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk_i);
    #1;
  endtask

  function automatic logic [11:0] idx(input logic [23:0] addr, input int k);
    logic [23:0] a;
    a = addr + 24'(k);
    return a[11:0];
  endfunction

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy_o && i < 200) begin
      step();
      i++;
    end
    if (busy_o) check({name, " idle timeout"}, busy_o, 0);
  endtask

  // Issues one burst from IDLE and follows it to completion.
  // exp_lat < 0 skips the latency check (used when refresh may intervene).
  task automatic run_burst(input bit is_rd, input logic [23:0] addr, input logic [9:0] len,
                           input logic [15:0] base, input int exp_lat, input string name);
    int t, first, last, nack;
    bit gap;
    logic [11:0] li;
    wait_idle(name);
    t = cyc; first = -1; last = -1; nack = 0; gap = 0;
    if (is_rd) begin
      sdram_rd_req_i = 1'b1; sdram_rd_addr_i = addr; sdram_rd_length_i = len;
    end else begin
      sdram_wr_req_i = 1'b1; sdram_wr_addr_i = addr; sdram_wr_length_i = len;
      sdram_wr_data_i = base;
    end
    for (int i = 0; i < int'(len) + 60; i++) begin
      @(negedge sys_clk_i);
      if (is_rd ? sdram_rd_ack_o : sdram_wr_ack_o) begin
        if (first < 0) first = cyc;
        else if (cyc != last + 1) gap = 1;
        last = cyc;
        li = idx(addr, nack);
        if (is_rd) begin
          if (valid[li]) check($sformatf("%s word%0d", name, nack), sdram_rd_data_o, shadow[li]);
        end else begin
          shadow[li] = 16'(base + 16'(nack));
          valid[li]  = 1'b1;
        end
        nack++;
      end
      if (nack == int'(len) && !busy_o) break;
      step();
      if (nack > 0) begin
        sdram_rd_req_i = 1'b0;
        sdram_wr_req_i = 1'b0;
      end
      if (!is_rd) sdram_wr_data_i = 16'(base + 16'(nack));
    end
    check({name, " ack count"}, nack, len);
    check({name, " contiguous"}, gap, 0);
    if (exp_lat >= 0) check({name, " latency"}, first - t, exp_lat);
    if (is_rd && nack > 0) begin
      li = idx(addr, nack - 1);
      if (valid[li]) check({name, " data hold"}, sdram_rd_data_o, shadow[li]);
    end
    sdram_rd_req_i = 1'b0;
    sdram_wr_req_i = 1'b0;
    step();
  endtask

  initial begin
    int t, cur, nack;
    bit exp_wr [12];
    bit exp_rd [12];
    bit rd_seen, wr_seen;

    vecs[0] = '{1'b0, 24'h000010, 10'd4, 16'h00A0, 1};
    vecs[1] = '{1'b1, 24'h000010, 10'd4, 16'h0000, 2};
    vecs[2] = '{1'b0, 24'hFFFFFE, 10'd4, 16'h00B0, 1};
    vecs[3] = '{1'b1, 24'hFFFFFE, 10'd4, 16'h0000, 2};
    vecs[4] = '{1'b1, 24'h000FFE, 10'd4, 16'h0000, 2};
    vecs[5] = '{1'b1, 24'h000000, 10'd2, 16'h0000, 2};
    vecs[6] = '{1'b0, 24'h123011, 10'd1, 16'h00C5, 1};
    vecs[7] = '{1'b1, 24'h000010, 10'd4, 16'h0000, 2};

    // ---------------- reset values ----------------
    step(); step();
    @(negedge sys_clk_i);
    check("rst wr_ack",  sdram_wr_ack_o, 0);
    check("rst rd_ack",  sdram_rd_ack_o, 0);
    check("rst refresh", refresh_o, 0);
    check("rst busy",    busy_o, 0);
    check("rst rd_data", sdram_rd_data_o, 0);
    step();
    rst_i = 1'b0;
    n0 = cyc;

    // ---------------- simultaneous requests: W, R, W ----------------
    step();
    for (int i = 0; i < 12; i++) begin exp_wr[i] = 0; exp_rd[i] = 0; end
    cur = 0;
    for (int b = 0; b < 3; b++) begin
      if (b % 2 == 0) begin
        for (int k = 1; k <= 2; k++) exp_wr[cur + k] = 1;
        cur += 2 + 2;
      end else begin
        for (int k = 2; k <= 3; k++) exp_rd[cur + k] = 1;
        cur += 2 + 3;
      end
    end
    sdram_wr_req_i = 1'b1; sdram_wr_addr_i = 24'h000200; sdram_wr_length_i = 10'd2;
    sdram_wr_data_i = 16'h5A5A;
    sdram_rd_req_i = 1'b1; sdram_rd_addr_i = 24'h000300; sdram_rd_length_i = 10'd2;
    t = cyc;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk_i);
      check($sformatf("rr wr_ack c%0d", i), sdram_wr_ack_o, exp_wr[i]);
      check($sformatf("rr rd_ack c%0d", i), sdram_rd_ack_o, exp_rd[i]);
      step();
    end
    sdram_wr_req_i = 1'b0;
    sdram_rd_req_i = 1'b0;
    shadow[12'h200] = 16'h5A5A; valid[12'h200] = 1'b1;
    shadow[12'h201] = 16'h5A5A; valid[12'h201] = 1'b1;
    wait_idle("rr");

    // ---------------- table-driven bursts ----------------
    foreach (vecs[i])
      run_burst(vecs[i].is_rd, vecs[i].addr, vecs[i].len, vecs[i].base, vecs[i].exp_lat,
                $sformatf("vec%0d", i));
    check("wrap idx 0x000", shadow[12'h000], 16'h00B2);
    check("wrap idx 0xFFF", shadow[12'hFFF], 16'h00B1);

    // ---------------- length 0 write, then priority toggle ----------------
    wait_idle("len0");
    sdram_wr_req_i = 1'b1; sdram_wr_addr_i = 24'h000050; sdram_wr_length_i = 10'd0;
    @(negedge sys_clk_i);
    check("len0 busy c0", busy_o, 0);
    step();
    sdram_wr_req_i = 1'b0;
    @(negedge sys_clk_i);
    check("len0 busy c1 (DONE)", busy_o, 1);
    check("len0 no wr_ack", sdram_wr_ack_o, 0);
    step();
    @(negedge sys_clk_i);
    check("len0 busy c2", busy_o, 0);
    check("len0 no wr_ack c2", sdram_wr_ack_o, 0);
    step();
    // Last served was the length-0 write, so a tie must go to read.
    sdram_wr_req_i = 1'b1; sdram_wr_addr_i = 24'h000060; sdram_wr_length_i = 10'd1;
    sdram_wr_data_i = 16'h1111;
    sdram_rd_req_i = 1'b1; sdram_rd_addr_i = 24'h000010; sdram_rd_length_i = 10'd1;
    @(negedge sys_clk_i);
    step();
    @(negedge sys_clk_i);
    check("prio c1 wr_ack", sdram_wr_ack_o, 0);
    step();
    @(negedge sys_clk_i);
    check("prio c2 rd_ack", sdram_rd_ack_o, 1);
    check("prio c2 wr_ack", sdram_wr_ack_o, 0);
    check("prio rd data",   sdram_rd_data_o, shadow[12'h010]);
    step();
    sdram_wr_req_i = 1'b0;
    sdram_rd_req_i = 1'b0;
    wait_idle("prio");

    // ---------------- reset on the 3rd ack of a 16-word read ----------------
    sdram_rd_req_i = 1'b1; sdram_rd_addr_i = 24'h000010; sdram_rd_length_i = 10'd16;
    t = cyc;
    nack = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk_i);
      if (sdram_rd_ack_o) nack++;
      if (nack == 3) break;
      step();
      if (nack > 0) sdram_rd_req_i = 1'b0;
    end
    check("rstmid 3rd ack cycle", cyc - t, 4);
    #2 rst_i = 1'b1;
    #1;
    check("rstmid rd_ack", sdram_rd_ack_o, 0);
    check("rstmid busy",   busy_o, 0);
    check("rstmid rd_data", sdram_rd_data_o, 0);
    sdram_rd_req_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    n0 = cyc;
    check("rstmid post busy", busy_o, 0);
    run_burst(1'b0, 24'h000700, 10'd2, 16'h00D0, 1, "post_rst wr");
    run_burst(1'b1, 24'h000700, 10'd2, 16'h0000, 2, "post_rst rd");

    // ---------------- refresh arriving during a burst ----------------
    while (cyc < n0 + 770) step();
    rd_seen = 0; wr_seen = 0;
    for (int i = 770; i < 806; i++) begin
      if (i == 770) begin
        sdram_rd_req_i = 1'b1; sdram_rd_addr_i = 24'h000010; sdram_rd_length_i = 10'd16;
      end
      if (i == 775) begin
        sdram_wr_req_i = 1'b1; sdram_wr_addr_i = 24'h000400; sdram_wr_length_i = 10'd2;
        sdram_wr_data_i = 16'h7777;
      end
      if (rd_seen) sdram_rd_req_i = 1'b0;
      if (wr_seen) sdram_wr_req_i = 1'b0;
      @(negedge sys_clk_i);
      check($sformatf("ref rd_ack c%0d", i), sdram_rd_ack_o, (i >= 772 && i <= 787));
      check($sformatf("ref refresh c%0d", i), refresh_o, (i >= 790 && i <= 797));
      check($sformatf("ref wr_ack c%0d", i), sdram_wr_ack_o, (i >= 799 && i <= 800));
      if (sdram_rd_ack_o) rd_seen = 1;
      if (sdram_wr_ack_o) begin
        wr_seen = 1;
        shadow[12'h400 + 12'(i - 799)] = 16'h7777;
        valid[12'h400 + 12'(i - 799)]  = 1'b1;
      end
      step();
    end
    sdram_rd_req_i = 1'b0;
    sdram_wr_req_i = 1'b0;
    wait_idle("ref");
    run_burst(1'b1, 24'h000400, 10'd2, 16'h0000, -1, "ref readback");

    // ---------------- randomized bursts vs memory model ----------------
    for (int n = 0; n < 60; n++) begin
      logic [23:0] a;
      logic [9:0]  l;
      a = {12'($urandom_range(0, 4095)),
           ($urandom_range(0, 3) == 0) ? 12'($urandom_range(12'hFF0, 12'hFFF))
                                       : 12'($urandom_range(0, 63))};
      l = 10'($urandom_range(1, 12));
      run_burst(1'($urandom_range(0, 1)), a, l, 16'($urandom), -1, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_responder.md
# sdram_port_responder

Responder end of the team's SDRAM client port (req/ack/addr/length, write and read channels). It accepts write and read burst requests from a client block, arbitrates between them, stores data in an internal on-chip word memory, and paces each burst with per-word acks. It also emulates periodic refresh blackouts. It stands in for the SDRAM controller in simulation and small-FPGA builds, so client blocks can be exercised without external memory.

## Interface
- ADDR_WIDTH, 24, client word-address width
- DATA_WIDTH, 16, data word width
- LEN_WIDTH, 10, burst-length field width
- MEM_AW, 12, internal memory address width (2^MEM_AW words)
- REFRESH_PERIOD, 780, cycles between refresh requests
- REFRESH_CYCLES, 8, cycles the port is blocked per refresh

Ports:
- sys_clk_i  in  1  sole clock; all logic on its rising edge
- rst_i  in  1  reset, asynchronous, active-high
- sdram_wr_req_i  in  1  write burst request, level
- sdram_wr_addr_i  in  ADDR_WIDTH  write start word address
- sdram_wr_data_i  in  DATA_WIDTH  write data; current word must be valid whenever req is high
- sdram_wr_length_i  in  LEN_WIDTH  write burst length in words
- sdram_wr_ack_o  out  1  write word accepted this cycle
- sdram_rd_req_i  in  1  read burst request, level
- sdram_rd_addr_i  in  ADDR_WIDTH  read start word address
- sdram_rd_length_i  in  LEN_WIDTH  read burst length in words
- sdram_rd_data_o  out  DATA_WIDTH  read data, valid when sdram_rd_ack_o is high
- sdram_rd_ack_o  out  1  read word valid this cycle
- refresh_o  out  1  high while in REF
- busy_o  out  1  high in any state other than IDLE

## Operation
- States: IDLE, REF, WR, RD_PRE, RD, DONE.
- IDLE decision order: refresh pending goes to REF. Otherwise, a single active req goes to that channel. If both reqs are high, the channel not served last wins (round-robin). Priority resets to write.
- req, addr and length are sampled only in IDLE. They are latched at grant and ignored until DONE. Deasserting req mid-burst does not shorten the burst.
- Length 0: the granted channel goes straight to DONE with no ack. Priority still toggles.
- WR: ack is high for exactly L cycles. Word k (k = 0..L-1) is written on ack cycle k to address (addr+k). The client must present word k+1 on the cycle after ack k.
- RD_PRE: lasts 1 cycle and issues the read of word 0. RD: ack is high for exactly L cycles, and sdram_rd_data_o carries word k on ack cycle k.
- Address arithmetic: addr+k wraps modulo 2^ADDR_WIDTH. The memory index is the low MEM_AW bits, so the memory aliases and wraps silently.
- DONE: 1 cycle, then IDLE. This guarantees a gap of at least 2 cycles between bursts, so a level req from the client can update.
- Refresh counter: free-running 0..REFRESH_PERIOD-1. At the wrap it sets refresh_pending. A second wrap while pending does not queue a second refresh.
- Refresh never interrupts a burst. It is taken at the next IDLE, and pending is cleared on REF entry. REF lasts REFRESH_CYCLES cycles, then goes to IDLE.
- sdram_rd_data_o holds its last value outside ack cycles.
- Memory contents are not reset. A write and a read to the same address never occur together, because the channels are exclusive.

## Timing
- Reset values: state IDLE; all acks 0; refresh_o 0; busy_o 0; sdram_rd_data_o 0; refresh counter 0; pending 0; priority write.
- Reset mid-burst: acks drop asynchronously and the burst is abandoned. Words already written stay in memory.
- Write latency: req seen high in IDLE at cycle t; ack high cycles t+1..t+L; DONE at t+L+1; IDLE at t+L+2.
- Read latency: req seen at t; RD_PRE at t+1; ack cycles t+2..t+L+1; DONE at t+L+2.
- Request during REF or a burst: waits. The first grant is the cycle after the return to IDLE is evaluated.
- Acks are registered outputs. Memory reads are synchronous, with 1-cycle latency.

## Structure
- Package sdram_port_pkg holds the state enum, default width constants, and a burst-descriptor typedef (addr, len, is_read).
- Sub-module simple_dp_ram: 1 write port plus 1 synchronous read port, parameterised by MEM_AW and DATA_WIDTH.
- The top level holds the FSM, arbiter, word counter, address incrementer and refresh counter.

## Test plan
- Write, then read: wr addr 0x000010, L=4, data 0xA0..0xA3 -> ack for 4 consecutive cycles from t+1. A later rd of the same address and L returns 0xA0..0xA3 on ack cycles t+2..t+5.
- Simultaneous requests: wr and rd req rise in the same cycle after reset -> WR is served first, then RD. Holding both high alternates WR, RD, WR.
- Length 0: wr req with L=0 -> no ack, busy_o high for 1 cycle (DONE), then IDLE.
- Refresh: request arrives while a burst is active at the counter wrap -> burst completes unbroken. REF follows with refresh_o high for 8 cycles, then the pending req is granted.
- Address wrap: wr addr 0xFFFFFE, L=4 -> words land at memory indices 0xFFE, 0xFFF, 0x000, 0x001. Read-back matches.
- Reset mid-burst: rst_i asserted on the 3rd ack of a 16-word read -> acks 0 immediately. After release: IDLE, and the next request is served normally.
